// File: rtl/anf_pkg.sv
// Shared types, constants and saturation helpers for the multi-channel adaptive notch.
package anf_pkg;

  // Default widths; the top exposes these as overridable parameters.
  localparam int ANF_DATA_SIZE = 24;
  localparam int ANF_COEF_SIZE = 35;
  localparam int FRAC          = ANF_COEF_SIZE - 3;
  // Aligns a DATA x DATA gradient product onto the coefficient's fractional grid.
  localparam int GRAD_SHIFT    = 2 * ANF_DATA_SIZE - 2 - FRAC;
  // Width of the working intermediates; wide enough that nothing wraps before saturation.
  localparam int XW            = 128;

  // One multiply per state; only IDLE waits on an input.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RA,
    ST_RAS1,
    ST_R2S2,
    ST_Y,
    ST_GRAD,
    ST_UPD
  } anf_state_t;

  // Clip v to the signed range of a w-bit integer.
  function automatic logic signed [XW-1:0] sat_w(input logic signed [XW-1:0] v, input int w);
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    hi = '1;
    hi = hi >> (XW - w + 1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [XW-1:0] sat_data(input logic signed [XW-1:0] v, input int w);
    return sat_w(v, w);
  endfunction

  function automatic logic signed [XW-1:0] sat_coef(input logic signed [XW-1:0] v, input int w);
    return sat_w(v, w);
  endfunction

  // Coefficient a = -2cos(w0) lives in [-2, 2); clamp to that range in Q.frac.
  function automatic logic signed [XW-1:0] clamp_a(input logic signed [XW-1:0] v, input int frac);
    return sat_w(v, frac + 2);
  endfunction

endpackage

// File: rtl/anf_mul_shared.sv
// The single shared signed multiplier; operands are selected by the FSM state.
module anf_mul_shared import anf_pkg::*; #(
  parameter int DATA_SIZE = ANF_DATA_SIZE,
  parameter int COEF_SIZE = ANF_COEF_SIZE
) (
  input  anf_state_t                      state,
  input  logic signed [COEF_SIZE-1:0]     r_coef,
  input  logic signed [COEF_SIZE-1:0]     r2_coef,
  input  logic signed [COEF_SIZE-1:0]     a_coef,
  input  logic signed [COEF_SIZE-1:0]     ra_coef,
  input  logic signed [DATA_SIZE-1:0]     s1,
  input  logic signed [DATA_SIZE-1:0]     s2,
  input  logic signed [DATA_SIZE-1:0]     y,
  output logic signed [2*COEF_SIZE-1:0]   prod
);

  logic signed [COEF_SIZE-1:0] op_a;
  logic signed [COEF_SIZE-1:0] op_b;

  // Operand select: each state owns exactly one product.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      ST_RA:   begin op_a = r_coef;            op_b = a_coef;            end
      ST_RAS1: begin op_a = ra_coef;           op_b = COEF_SIZE'(s1);    end
      ST_R2S2: begin op_a = r2_coef;           op_b = COEF_SIZE'(s2);    end
      ST_Y:    begin op_a = a_coef;            op_b = COEF_SIZE'(s1);    end
      ST_GRAD: begin op_a = COEF_SIZE'(y);     op_b = COEF_SIZE'(s1);    end
      default: begin op_a = '0;                op_b = '0;                end
    endcase
  end

  assign prod = (2*COEF_SIZE)'(op_a) * (2*COEF_SIZE)'(op_b);

endmodule

// File: rtl/adaptive_notch_mc.sv
// Time-multiplexed N-channel adaptive IIR notch with LMS-tracked a = -2cos(w0).
module adaptive_notch_mc import anf_pkg::*; #(
  parameter int DATA_SIZE = ANF_DATA_SIZE,
  parameter int COEF_SIZE = ANF_COEF_SIZE,
  parameter int CHANNELS  = 4,
  parameter logic signed [COEF_SIZE-1:0] A_INIT = '0,
  parameter logic signed [COEF_SIZE-1:0] R      = COEF_SIZE'(64'sd4080218931),
  parameter logic signed [COEF_SIZE-1:0] R2     = COEF_SIZE'(64'sd3876207985),
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH_W-1:0]              in_ch,
  input  logic signed [DATA_SIZE-1:0]  data_in,
  input  logic [4:0]                   mu_shift,
  input  logic                         freeze,
  output logic                         out_valid,
  output logic [CH_W-1:0]              out_ch,
  output logic signed [DATA_SIZE-1:0]  data_out,
  output logic signed [COEF_SIZE-1:0]  a_out
);

  localparam int CF = COEF_SIZE - 3;
  localparam int GS = 2 * DATA_SIZE - 2 - CF;

  anf_state_t state_reg, state_next;

  logic signed [DATA_SIZE-1:0]   x_reg, s_reg, y_reg;
  logic [CH_W-1:0]               ch_reg;
  logic [4:0]                    mu_reg;
  logic                          frz_reg;
  logic signed [COEF_SIZE-1:0]   ra_reg;
  logic signed [XW-1:0]          acc_reg;
  logic signed [2*DATA_SIZE-1:0] g_reg;

  logic signed [DATA_SIZE-1:0]   s1_arr [CHANNELS];
  logic signed [DATA_SIZE-1:0]   s2_arr [CHANNELS];
  logic signed [COEF_SIZE-1:0]   a_arr  [CHANNELS];
  logic signed [DATA_SIZE-1:0]   s1_cur, s2_cur;
  logic signed [COEF_SIZE-1:0]   a_cur;

  logic signed [2*COEF_SIZE-1:0] prod;
  logic signed [XW-1:0]          prod_x, prod_sh, acc_next;
  logic signed [COEF_SIZE-1:0]   ra_next, a_clamped, a_new;
  logic signed [DATA_SIZE-1:0]   s_next, y_next;

  logic accept, ch_ok, wr_en;

  assign accept = in_valid && in_ready && !clear;
  assign wr_en  = (state_reg == ST_UPD) && ch_ok && !clear;

  // Tags beyond CHANNELS are consumed silently; only possible when CHANNELS is not a power of two.
  if (CHANNELS < (1 << CH_W)) begin : g_chk
    assign ch_ok = (int'(ch_reg) < CHANNELS);
  end else begin : g_nochk
    assign ch_ok = 1'b1;
  end

  assign s1_cur = s1_arr[ch_reg];
  assign s2_cur = s2_arr[ch_reg];
  assign a_cur  = a_arr[ch_reg];

  anf_mul_shared #(
    .DATA_SIZE (DATA_SIZE),
    .COEF_SIZE (COEF_SIZE)
  ) u_mul (
    .state   (state_reg),
    .r_coef  (R),
    .r2_coef (R2),
    .a_coef  (a_cur),
    .ra_coef (ra_reg),
    .s1      (s1_cur),
    .s2      (s2_cur),
    .y       (y_reg),
    .prod    (prod)
  );

  assign prod_x = XW'(prod);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and ready: a fixed 7-cycle walk, clear forces IDLE.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_RA;
      end
      ST_RA:   state_next = ST_RAS1;
      ST_RAS1: state_next = ST_R2S2;
      ST_R2S2: state_next = ST_Y;
      ST_Y:    state_next = ST_GRAD;
      ST_GRAD: state_next = ST_UPD;
      ST_UPD:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  // Per-state arithmetic, kept wide until each saturation point.
  always_comb begin
    prod_sh   = prod_x >>> CF;
    ra_next   = COEF_SIZE'(sat_coef(prod_sh, COEF_SIZE));
    acc_next  = XW'(x_reg) - prod_sh;
    s_next    = DATA_SIZE'(sat_data(acc_reg - prod_sh, DATA_SIZE));
    y_next    = DATA_SIZE'(sat_data(XW'(s_reg) + XW'(s2_cur) + prod_sh, DATA_SIZE));
    a_clamped = COEF_SIZE'(clamp_a(XW'(a_cur) - (XW'(g_reg) >>> (GS + int'(mu_reg))), CF));
    a_new     = frz_reg ? a_cur : a_clamped;
  end

  // Sample latch at accept and pipeline of per-state intermediates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg   <= '0;
      ch_reg  <= '0;
      mu_reg  <= '0;
      frz_reg <= 1'b0;
      ra_reg  <= '0;
      acc_reg <= '0;
      s_reg   <= '0;
      y_reg   <= '0;
      g_reg   <= '0;
    end else begin
      if (accept) begin
        x_reg   <= data_in;
        ch_reg  <= in_ch;
        mu_reg  <= mu_shift;
        frz_reg <= freeze;
      end
      case (state_reg)
        ST_RA:   ra_reg  <= ra_next;
        ST_RAS1: acc_reg <= acc_next;
        ST_R2S2: s_reg   <= s_next;
        ST_Y:    y_reg   <= y_next;
        ST_GRAD: g_reg   <= prod[2*DATA_SIZE-1:0];
        default: ;
      endcase
    end
  end

  // Result registers; they hold between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      data_out  <= '0;
      a_out     <= A_INIT;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= wr_en;
      if (wr_en) begin
        out_ch   <= ch_reg;
        data_out <= y_reg;
        a_out    <= a_new;
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic signed [DATA_SIZE-1:0] s1_reg, s2_reg;
    logic signed [COEF_SIZE-1:0] a_reg;
    logic                        sel;

    assign sel = wr_en && (ch_reg == CH_W'(gi));

    // Channel state: delay line shifts on write-back; a only moves when not frozen.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_reg <= '0;
        s2_reg <= '0;
        a_reg  <= A_INIT;
      end else if (clear) begin
        s1_reg <= '0;
        s2_reg <= '0;
        a_reg  <= A_INIT;
      end else if (sel) begin
        s2_reg <= s1_reg;
        s1_reg <= s_reg;
        if (!frz_reg) a_reg <= a_new;
      end
    end

    assign s1_arr[gi] = s1_reg;
    assign s2_arr[gi] = s2_reg;
    assign a_arr[gi]  = a_reg;
  end

endmodule

// File: tb/tb_adaptive_notch_mc.sv
// Self-checking bench: hand-computed vectors, a floating-free reference model, and clear/timing corners.
module tb_adaptive_notch_mc;

  logic               clk = 1'b0;
  logic               reset, clear, in_valid, freeze;
  logic               in_ready;
  logic [1:0]         in_ch;
  logic signed [23:0] data_in;
  logic [4:0]         mu_shift;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic signed [23:0] data_out;
  logic signed [34:0] a_out;

  int checks = 0;
  int errors = 0;

  adaptive_notch_mc dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .data_in   (data_in),
    .mu_shift  (mu_shift),
    .freeze    (freeze),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .data_out  (data_out),
    .a_out     (a_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: the recursion computed in plain 128-bit arithmetic
  logic signed [127:0] m_a [4];
  logic signed [127:0] m_s1 [4];
  logic signed [127:0] m_s2 [4];

  function automatic logic signed [127:0] msat(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi, lo;
    hi = 1;
    hi = (hi <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_a[c] = 0; m_s1[c] = 0; m_s2[c] = 0;
    end
  endfunction

  function automatic void model_step(input int ch, input longint x, input int mu, input bit frz,
                                     output longint ey, output longint ea);
    logic signed [127:0] r, r2, xx, a, s1, s2, ra, acc, s, y, g, an;
    r  = 128'sd4080218931;      // round(0.95 * 2^32)
    r2 = 128'sd3876207985;      // round(0.9025 * 2^32)
    xx = x;
    a = m_a[ch]; s1 = m_s1[ch]; s2 = m_s2[ch];
    ra  = msat((r * a) >>> 32, 35);
    acc = xx - ((ra * s1) >>> 32);
    s   = msat(acc - ((r2 * s2) >>> 32), 24);
    y   = msat(s + s2 + ((a * s1) >>> 32), 24);
    g   = y * s1;
    an  = frz ? a : msat(a - (g >>> (14 + mu)), 34);
    m_a[ch] = an; m_s2[ch] = s1; m_s1[ch] = s;
    ey = longint'(y);
    ea = longint'(an);
  endfunction

  // ---------------- one handshake + wait for result, checking latency and ready shape
  task automatic send(input int ch, input longint x, input int mu, input bit frz,
                      output bit ok, output longint y, output longint a, output int och);
    int  n;
    bit  busy_bad;
    ok = 0; y = 0; a = 0; och = 0;
    @(negedge clk);
    in_ch    = ch[1:0];
    data_in  = x[23:0];
    mu_shift = mu[4:0];
    freeze   = frz;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    busy_bad = 0;
    for (n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        ok = 1;
        break;
      end
      if (in_ready) busy_bad = 1;
    end
    chk("latency", n, 6);
    chk("busy_ready", busy_bad, 0);
    if (ok) begin
      chk("ready_after", in_ready, 1);
      y   = longint'(data_out);
      a   = longint'(a_out);
      och = int'(out_ch);
    end
  endtask

  // Model-checked transaction.
  task automatic txn(input string tag, input int ch, input longint x, input int mu, input bit frz);
    longint ey, ea, y, a;
    int     och;
    bit     ok;
    model_step(ch, x, mu, frz, ey, ea);
    send(ch, x, mu, frz, ok, y, a, och);
    if (ok) begin
      chk({tag, "_y"}, y, ey);
      chk({tag, "_a"}, a, ea);
      chk({tag, "_ch"}, och, ch);
    end
    $display("txn %s ch=%0d x=%0d mu=%0d frz=%0d y=%0d a=%0d", tag, ch, x, mu, frz, y, a);
  endtask

  typedef struct {
    int     ch;
    longint x;
    int     mu;
    bit     frz;
    longint exp_y;
    longint exp_a;
  } vec_t;

  vec_t vecs [6];
  int   sin8 [8] = '{0, 741455, 1048576, 741455, 0, -741455, -1048576, -741455};
  int   sin4 [4] = '{0, 1048576, 0, -1048576};

  initial begin
    longint y, a, ey, ea, a_frozen;
    int     och;
    bit     ok, seen;

    // Fresh channels: y = x and a unchanged; then two hand-derived follow-ups on ch0.
    vecs[0] = '{0,      1000, 8, 0,    1000,    0};
    vecs[1] = '{1,        -5, 8, 0,      -5,    0};
    vecs[2] = '{2,   8388607, 8, 0, 8388607,    0};
    vecs[3] = '{3,  -8388608, 8, 0, -8388608,   0};
    vecs[4] = '{0,      2000, 0, 0,    2000, -122};
    vecs[5] = '{0,         0, 0, 1,      98, -122};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; freeze = 1'b0;
    in_ch = '0; data_in = '0; mu_shift = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a_out", longint'(a_out), 0);
    chk("rst_data_out", longint'(data_out), 0);
    chk("rst_out_ch", out_ch, 0);

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      model_step(vecs[i].ch, vecs[i].x, vecs[i].mu, vecs[i].frz, ey, ea);
      send(vecs[i].ch, vecs[i].x, vecs[i].mu, vecs[i].frz, ok, y, a, och);
      if (ok) begin
        chk($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
        chk($sformatf("vec%0d_a", i), a, vecs[i].exp_a);
        chk($sformatf("vec%0d_ch", i), och, vecs[i].ch);
      end
      $display("txn vec%0d ch=%0d x=%0d y=%0d a=%0d", i, vecs[i].ch, vecs[i].x, y, a);
    end

    // Randomized traffic across all channels, step sizes and occasional freeze.
    for (int i = 0; i < 200; i++) begin
      longint xr;
      xr = longint'($signed(24'($urandom)));
      txn("rnd", int'($urandom_range(0, 3)), xr, int'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0));
    end

    // Clear on the same edge as a handshake: the sample is ignored.
    @(negedge clk);
    in_ch = 2'd1; data_in = 24'sd4321; mu_shift = 5'd4; freeze = 1'b0;
    in_valid = 1'b1; clear = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; clear = 1'b0;
    model_reset();
    chk("clr_same_ready", in_ready, 1);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    chk("clr_same_no_valid", seen, 0);

    // Give ch0 history, then clear three cycles into a sample.
    txn("pre", 0, 500000, 4, 0);
    txn("pre", 0, -300000, 4, 0);
    @(negedge clk);
    in_ch = 2'd0; data_in = 24'sd777777; mu_shift = 5'd4; freeze = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_reset();
    chk("clr_mid_ready", in_ready, 1);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    chk("clr_mid_no_valid", seen, 0);
    model_step(0, 1000, 8, 0, ey, ea);
    send(0, 1000, 8, 0, ok, y, a, och);
    if (ok) begin
      chk("post_clr_y", y, 1000);
      chk("post_clr_a", a, 0);
    end
    $display("txn post_clr ch=0 x=1000 y=%0d a=%0d", y, a);

    // Interleaved sines: ch0 at fs/8, ch1 at fs/4, mu_shift=8.
    for (int n = 0; n < 600; n++) begin
      txn("conv0", 0, sin8[n % 8], 8, 0);
      txn("conv1", 1, sin4[n % 4], 8, 0);
    end

    // Untouched channels still hold A_INIT (frozen probe leaves a as is).
    send(2, 0, 8, 1, ok, y, a, och);
    if (ok) chk("idle_ch2_a", a, 0);
    send(3, 0, 8, 1, ok, y, a, och);
    if (ok) chk("idle_ch3_a", a, 0);
    model_step(2, 0, 8, 1, ey, ea);
    model_step(3, 0, 8, 1, ey, ea);

    // Freeze the adapted ch0: a must stay bit-identical while y keeps following the model.
    a_frozen = longint'(m_a[0]);
    for (int n = 0; n < 50; n++) begin
      txn("frz", 0, sin8[n % 8], 8, 1);
      chk("frz_hold_a", longint'(a_out), a_frozen);
    end

    // Full-scale square wave with the largest step: outputs clip, a stays clamped.
    for (int n = 0; n < 100; n++) begin
      txn("sat", 2, ((n / 4) % 2 == 0) ? 64'sd8388607 : -64'sd8388607, 0, 0);
      chk("sat_a_hi", (longint'(a_out) > 64'sd8589934591), 0);
      chk("sat_a_lo", (longint'(a_out) < -64'sd8589934592), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
